arc4_core_param: RTL
====================

// Module: arc4_core_param
// PURPOSE
//  Parametrised ARC4 decrypt core; successor of the fixed 24-bit-key core. Reads a length-prefixed
//  ciphertext from external ct memory and writes the length-prefixed plaintext to external pt memory.
//  Owns its 256x8 S-box. Optional printable-ASCII check gives a per-run verdict for key-search tops.
// PARAMETERS
//  KEY_BYTES        3  key length in bytes (1..16); KEY_W = 8*KEY_BYTES
//  CHECK_PRINTABLE  1  1: ok = all plaintext bytes in 0x20..0x7E; 0: ok = 1 on every completion
// PORTS
//  clk        in   1      single clock; all state on rising edge
//  rst        in   1      asynchronous, active-high reset
//  en         in   1      start request; accepted only while rdy=1
//  rdy        out  1      core idle, can accept en
//  key        in   KEY_W  key; byte 0 = key[KEY_W-1 -: 8]; sampled on accepted en
//  ct_addr    out  8      ciphertext memory address
//  ct_rddata  in   8      ciphertext data; sync RAM, valid 1 cycle after ct_addr
//  pt_addr    out  8      plaintext memory address
//  pt_rddata  in   8      unused by core (readback for tops); no functional effect
//  pt_wrdata  out  8      plaintext write data
//  pt_wren    out  1      plaintext write strobe, one cycle per byte
//  ok         out  1      verdict of last completed run; valid while rdy=1
// BEHAVIOUR
//  - Reset (async, any state): state=IDLE, rdy=1, ok=0, ct_addr=0, pt_addr=0, pt_wrdata=0, pt_wren=0,
//    i=j=0. Reset mid-run abandons it; S contents undefined, pt writes already issued stay in pt mem.
//  - Handshake: en=1 && rdy=1 at edge -> key latched, ok cleared, rdy=0 next cycle. en ignored while busy.
//    rdy returns to 1 the cycle after the last pt write; ok updates in that same cycle.
//  - States: IDLE -> INIT -> KSA -> LEN -> PRGA -> DONE -> IDLE.
//  - INIT: S[k]=k for k=0..255, one write/cycle, 256 cycles.
//  - KSA: i=0..255: j = j + S[i] + key_byte[i mod KEY_BYTES] (mod 256); swap S[i],S[j].
//    Sub-steps RD_SI, WT_SI, RD_SJ, WT_SJ, WR_SI, WR_SJ; 6 cycles/iteration; key index wraps at KEY_BYTES.
//  - LEN: read ct[0]=L; write pt[0]=L; i=j=0. L=0 -> straight to DONE, ok=1.
//  - PRGA k=1..L: i=i+1; j=j+S[i]; swap S[i],S[j]; pad=S[(S[i]+S[j]) mod 256];
//    pt[k]=pad ^ ct[k]. ct[k] read overlaps S reads; one pt_wren pulse per k.
//  - All index arithmetic 8-bit, modulo 256 (wrap silent). k counts to L<=255, no overflow.
//  - Swap with i==j: both writes target same address, value unchanged; must not corrupt S.
//  - ok: CHECK_PRINTABLE=1 -> AND over k=1..L of (0x20<=pt[k]<=0x7E), pt[0] excluded; L=0 -> 1.
//  - Latency budget: 256 + 1536 + LEN(<=4) + <=10 cycles/byte; testbench timeout 4000 cycles.
//  - Outputs registered; pt_wren never asserted while rdy=1.
// STRUCTURE
//  - arc4_pkg: state enum (IDLE, INIT, KSA_*, LEN_*, PRGA_*, DONE), PRINT_LO=8'h20,
//    PRINT_HI=8'h7E, SBOX_DEPTH=256.
//  - Sub-module arc4_s_ram: 256x8 single-port sync RAM (addr, wrdata, wren, rddata, 1-cycle read).
//  - Core: one FSM + datapath (i, j, k, L, tmp_si, tmp_sj, key index, ok accumulator).
// TESTING
//  1. KEY_BYTES=3, key=24'h4B6579, ct={09,BB,F3,16,E8,D9,40,AF,0A,D3} -> pt={09,"Plaintext"}, ok=1.
//  2. KEY_BYTES=4, key=32'h57696B69, ct={05,10,21,BF,04,20} -> pt={05,"pedia"}, ok=1.
//  3. Key 24'h4B657A with vector 1 ciphertext -> pt differs from "Plaintext", ok=0 (CHECK_PRINTABLE=1).
//  4. ct[0]=00 -> only pt[0]=00 written (one pt_wren pulse), rdy back <=300+1536 cycles, ok=1.
//  5. Pulse en repeatedly during KSA -> no restart; single pt write sequence; result as test 1.
//  6. Assert rst for 1 cycle mid-KSA -> rdy=1, ok=0, pt_wren=0 immediately; rerun test 1 passes.

Source files
------------

// File: rtl/arc4_core_param_pkg.sv
// Shared types and constants for the parametrised ARC4 decrypt core.
package arc4_core_param_pkg;

    localparam int unsigned BYTE_W     = 8;
    localparam int unsigned SBOX_DEPTH = 256;
    localparam logic [7:0]  PRINT_LO   = 8'h20;
    localparam logic [7:0]  PRINT_HI   = 8'h7E;

    // Control sequence; *_WT_* states cover the one-cycle sync RAM read latency.
    typedef enum logic [4:0] {
        IDLE,
        INIT,
        KSA_RD_SI,
        KSA_WT_SI,
        KSA_RD_SJ,
        KSA_WT_SJ,
        KSA_WR_SI,
        KSA_WR_SJ,
        LEN_RD,
        LEN_WT,
        LEN_WR,
        PRGA_RD_SI,
        PRGA_WT_SI,
        PRGA_RD_SJ,
        PRGA_WT_SJ,
        PRGA_WR_SI,
        PRGA_WR_SJ,
        PRGA_RD_PAD,
        PRGA_WT_PAD,
        PRGA_XOR,
        DONE
    } arc4_state_e;

    // True for printable ASCII (space through tilde).
    function automatic logic is_printable(input logic [7:0] b);
        return (b >= PRINT_LO) && (b <= PRINT_HI);
    endfunction

endpackage

// File: rtl/arc4_core_param_if.sv
// Handshake and memory bus between a key-search top (master) and the core (slave).
interface arc4_core_param_if #(
    parameter int unsigned KEY_BYTES = 3
) ();
    localparam int unsigned KEY_W = 8 * KEY_BYTES;

    logic             en;
    logic             rdy;
    logic [KEY_W-1:0] key;
    logic [7:0]       ct_addr;
    logic [7:0]       ct_rddata;
    logic [7:0]       pt_addr;
    logic [7:0]       pt_rddata;
    logic [7:0]       pt_wrdata;
    logic             pt_wren;
    logic             ok;

    modport master (
        output en, key, ct_rddata, pt_rddata,
        input  rdy, ct_addr, pt_addr, pt_wrdata, pt_wren, ok
    );

    modport slave (
        input  en, key, ct_rddata, pt_rddata,
        output rdy, ct_addr, pt_addr, pt_wrdata, pt_wren, ok
    );
endinterface

// File: rtl/arc4_core_param_s_ram.sv
// 256x8 single-port synchronous RAM holding the ARC4 permutation.
module arc4_core_param_s_ram
    import arc4_core_param_pkg::*;
(
    input  logic       clk,
    input  logic [7:0] addr_i,
    input  logic [7:0] wrdata_i,
    input  logic       wren_i,
    output logic [7:0] rddata_o
);
    logic [7:0] mem [SBOX_DEPTH];

    // Write on strobe; read-first registered output, valid one cycle after addr_i.
    always_ff @(posedge clk) begin
        if (wren_i) begin
            mem[addr_i] <= wrdata_i;
        end
        rddata_o <= mem[addr_i];
    end
endmodule

// File: rtl/arc4_core_param.sv
// ARC4 decrypt core: length-prefixed ct memory in, length-prefixed pt memory out,
// with an optional printable-ASCII verdict per run.
module arc4_core_param
    import arc4_core_param_pkg::*;
#(
    parameter int unsigned KEY_BYTES       = 3,
    parameter int unsigned CHECK_PRINTABLE = 1
) (
    input  logic               clk,
    input  logic               rst,
    arc4_core_param_if.slave   bus
);
    localparam int unsigned KEY_W = 8 * KEY_BYTES;

    arc4_state_e      state_q;
    logic [7:0]       i_q;
    logic [7:0]       j_q;
    logic [7:0]       k_q;
    logic [7:0]       len_q;
    logic [7:0]       tmp_si_q;
    logic [7:0]       tmp_sj_q;
    logic [7:0]       ct_byte_q;
    logic [KEY_W-1:0] key_q;
    logic             ok_acc_q;

    logic             rdy_q;
    logic             ok_q;
    logic [7:0]       ct_addr_q;
    logic [7:0]       pt_addr_q;
    logic [7:0]       pt_wrdata_q;
    logic             pt_wren_q;

    logic [7:0]       s_addr_q;
    logic [7:0]       s_wdata_q;
    logic             s_wren_q;
    logic [7:0]       s_rddata;

    logic [7:0]       key_byte;
    logic [7:0]       i_inc_d;
    logic [7:0]       j_ksa_d;
    logic [7:0]       j_prga_d;
    logic [7:0]       pad_idx_d;
    logic [7:0]       pt_byte_d;
    logic             ok_byte_d;
    logic [KEY_W-1:0] key_rot_d;

    arc4_core_param_s_ram u_s_ram (
        .clk      (clk),
        .addr_i   (s_addr_q),
        .wrdata_i (s_wdata_q),
        .wren_i   (s_wren_q),
        .rddata_o (s_rddata)
    );

    assign bus.rdy       = rdy_q;
    assign bus.ok        = ok_q;
    assign bus.ct_addr   = ct_addr_q;
    assign bus.pt_addr   = pt_addr_q;
    assign bus.pt_wrdata = pt_wrdata_q;
    assign bus.pt_wren   = pt_wren_q;

    // Datapath arithmetic (all mod 256); the key register rotates one byte per KSA step,
    // so its top byte is always key_byte[i mod KEY_BYTES].
    always_comb begin
        key_byte  = key_q[KEY_W-1 -: 8];
        i_inc_d   = i_q + 8'd1;
        j_ksa_d   = j_q + s_rddata + key_byte;
        j_prga_d  = j_q + s_rddata;
        pad_idx_d = tmp_si_q + tmp_sj_q;
        pt_byte_d = s_rddata ^ ct_byte_q;
        ok_byte_d = (CHECK_PRINTABLE != 0) ? is_printable(pt_byte_d) : 1'b1;
        key_rot_d = (key_q << 8) | (key_q >> (KEY_W - 8));
    end

    // Control FSM with registered outputs and S-RAM port.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            i_q         <= 8'd0;
            j_q         <= 8'd0;
            k_q         <= 8'd0;
            len_q       <= 8'd0;
            tmp_si_q    <= 8'd0;
            tmp_sj_q    <= 8'd0;
            ct_byte_q   <= 8'd0;
            key_q       <= '0;
            ok_acc_q    <= 1'b0;
            rdy_q       <= 1'b1;
            ok_q        <= 1'b0;
            ct_addr_q   <= 8'd0;
            pt_addr_q   <= 8'd0;
            pt_wrdata_q <= 8'd0;
            pt_wren_q   <= 1'b0;
            s_addr_q    <= 8'd0;
            s_wdata_q   <= 8'd0;
            s_wren_q    <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    pt_wren_q <= 1'b0;
                    s_wren_q  <= 1'b0;
                    if (bus.en && rdy_q) begin
                        key_q     <= bus.key;
                        ok_q      <= 1'b0;
                        rdy_q     <= 1'b0;
                        ok_acc_q  <= 1'b1;
                        i_q       <= 8'd0;
                        j_q       <= 8'd0;
                        ct_addr_q <= 8'd0;
                        state_q   <= INIT;
                    end
                end
                INIT: begin
                    s_addr_q  <= i_q;
                    s_wdata_q <= i_q;
                    s_wren_q  <= 1'b1;
                    i_q       <= i_inc_d;
                    if (i_q == 8'hFF) begin
                        state_q <= KSA_RD_SI;
                    end
                end
                KSA_RD_SI: begin
                    s_addr_q <= i_q;
                    s_wren_q <= 1'b0;
                    state_q  <= KSA_WT_SI;
                end
                KSA_WT_SI: state_q <= KSA_RD_SJ;
                KSA_RD_SJ: begin
                    tmp_si_q <= s_rddata;
                    j_q      <= j_ksa_d;
                    s_addr_q <= j_ksa_d;
                    state_q  <= KSA_WT_SJ;
                end
                KSA_WT_SJ: state_q <= KSA_WR_SI;
                KSA_WR_SI: begin
                    tmp_sj_q  <= s_rddata;
                    s_addr_q  <= i_q;
                    s_wdata_q <= s_rddata;
                    s_wren_q  <= 1'b1;
                    state_q   <= KSA_WR_SJ;
                end
                KSA_WR_SJ: begin
                    s_addr_q  <= j_q;
                    s_wdata_q <= tmp_si_q;
                    s_wren_q  <= 1'b1;
                    i_q       <= i_inc_d;
                    key_q     <= key_rot_d;
                    state_q   <= (i_q == 8'hFF) ? LEN_RD : KSA_RD_SI;
                end
                LEN_RD: begin
                    s_wren_q  <= 1'b0;
                    ct_addr_q <= 8'd0;
                    state_q   <= LEN_WT;
                end
                LEN_WT: state_q <= LEN_WR;
                LEN_WR: begin
                    len_q       <= bus.ct_rddata;
                    pt_addr_q   <= 8'd0;
                    pt_wrdata_q <= bus.ct_rddata;
                    pt_wren_q   <= 1'b1;
                    i_q         <= 8'd0;
                    j_q         <= 8'd0;
                    k_q         <= 8'd1;
                    state_q     <= (bus.ct_rddata == 8'd0) ? DONE : PRGA_RD_SI;
                end
                PRGA_RD_SI: begin
                    pt_wren_q <= 1'b0;
                    s_wren_q  <= 1'b0;
                    i_q       <= i_inc_d;
                    s_addr_q  <= i_inc_d;
                    ct_addr_q <= k_q;
                    state_q   <= PRGA_WT_SI;
                end
                PRGA_WT_SI: state_q <= PRGA_RD_SJ;
                PRGA_RD_SJ: begin
                    tmp_si_q  <= s_rddata;
                    ct_byte_q <= bus.ct_rddata;
                    j_q       <= j_prga_d;
                    s_addr_q  <= j_prga_d;
                    state_q   <= PRGA_WT_SJ;
                end
                PRGA_WT_SJ: state_q <= PRGA_WR_SI;
                PRGA_WR_SI: begin
                    tmp_sj_q  <= s_rddata;
                    s_addr_q  <= i_q;
                    s_wdata_q <= s_rddata;
                    s_wren_q  <= 1'b1;
                    state_q   <= PRGA_WR_SJ;
                end
                PRGA_WR_SJ: begin
                    s_addr_q  <= j_q;
                    s_wdata_q <= tmp_si_q;
                    s_wren_q  <= 1'b1;
                    state_q   <= PRGA_RD_PAD;
                end
                PRGA_RD_PAD: begin
                    s_wren_q <= 1'b0;
                    s_addr_q <= pad_idx_d;
                    state_q  <= PRGA_WT_PAD;
                end
                PRGA_WT_PAD: state_q <= PRGA_XOR;
                PRGA_XOR: begin
                    pt_addr_q   <= k_q;
                    pt_wrdata_q <= pt_byte_d;
                    pt_wren_q   <= 1'b1;
                    ok_acc_q    <= ok_acc_q & ok_byte_d;
                    if (k_q == len_q) begin
                        state_q <= DONE;
                    end else begin
                        k_q     <= k_q + 8'd1;
                        state_q <= PRGA_RD_SI;
                    end
                end
                DONE: begin
                    pt_wren_q <= 1'b0;
                    rdy_q     <= 1'b1;
                    ok_q      <= ok_acc_q;
                    state_q   <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end
endmodule
